// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the mem_loader byte-stream memory writer.
// Frame layout: SYNC, ADDR_HI, ADDR_LO, LEN, data bytes, [CSUM when MEM_LOADER_CHECKSUM_EN].
package mem_loader_pkg;

  // Loader FSM states; CSUM is only visited when the checksum option is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // Default frame start byte.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Width of the remaining-byte counter: it must hold 1..256.
  localparam int CNT_W = 9;

  // LEN field value 0 encodes the largest frame.
  localparam logic [CNT_W-1:0] LEN_ZERO_COUNT = 9'd256;

  // The header holds a 16-bit address; only the low ADDR_W bits are used.
  localparam int HDR_ADDR_W = 16;

  // Converts the LEN header byte into the number of data bytes to expect.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len);
    if (len == 8'h00) begin
      return LEN_ZERO_COUNT;
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/mem_loader.sv
// mem_loader: parses framed bytes from the host link and writes them into program memory,
// holding the CPU in reset while a frame is in flight.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN adds a trailing CSUM byte; the 8-bit sum of
// ADDR_HI, ADDR_LO, LEN, data and CSUM must be zero for done, otherwise err pulses.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready are both high;
// in_valid/in_data are held by the sender until that edge, in_ready never depends on in_valid.
// ADDR_W must be in 9..16 (the header carries a 16-bit address).
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int         ADDR_W = 15,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e                  state_q;
  logic [HDR_ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [7:0]              wr_data_q;
  logic                    cpu_hold_q;
  logic                    done_q;
  logic                    accept;
  logic [HDR_ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]        cnt_d;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic       ok_q;
  logic       err_q;
`endif

  // Ready in every running state except the one-cycle FIN turnaround; low while reset is held.
  assign in_ready = rst_n && (state_q != ST_FIN);
  assign accept   = in_valid && in_ready;

  // Next address/count for a data byte; the address wraps in the low ADDR_W bits naturally.
  always_comb begin
    addr_d = addr_q + 16'd1;
    cnt_d  = cnt_q - 9'd1;
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  // Running checksum including the byte currently on the bus.
  always_comb begin
    sum_d = sum_q + in_data;
  end
`endif

  // Frame parser FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          // Anything other than SYNC is line noise and is dropped.
          if (accept && in_data == SYNC) begin
            state_q    <= ST_AHI;
            cpu_hold_q <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end
        end
        ST_AHI: begin
          if (accept) begin
            addr_q[15:8] <= in_data;
            state_q      <= ST_ALO;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
          end
        end
        ST_ALO: begin
          if (accept) begin
            addr_q[7:0] <= in_data;
            state_q     <= ST_LEN;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
          end
        end
        ST_LEN: begin
          if (accept) begin
            cnt_q   <= len_to_count(in_data);
            state_q <= ST_DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
          end
        end
        ST_DATA: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q[ADDR_W-1:0];
            wr_data_q <= in_data;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            if (cnt_q == 9'd1) state_q <= ST_CSUM;
`else
            if (cnt_q == 9'd1) state_q <= ST_FIN;
`endif
          end
        end
        ST_CSUM: begin
`ifdef MEM_LOADER_CHECKSUM_EN
          if (accept) begin
            ok_q    <= (sum_d == 8'h00);
            state_q <= ST_FIN;
          end
`else
          state_q <= ST_FIN;
`endif
        end
        ST_FIN: begin
          cpu_hold_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
          done_q     <= ok_q;
          err_q      <= !ok_q;
`else
          done_q     <= 1'b1;
`endif
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: reset checks, table of frames, mid-frame reset sequence.
// Works in both builds; with MEM_LOADER_CHECKSUM_EN each frame carries a CSUM byte.
module tb_mem_loader;

  localparam int AW = 15;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] got_q[$];
  int            got_cyc[$];
  logic          got_hold[$];
  int            done_cnt = 0;
  int            err_cnt  = 0;
  int            n_tests  = 0;
  int            n_fail   = 0;

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back({wr_addr, wr_data});
      got_cyc.push_back(cyc);
      got_hold.push_back(cpu_hold);
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    got_hold.delete();
  endtask

  // Compares logged writes against exp_q: count, contents, back-to-back timing, cpu_hold.
  task automatic compare_writes(input string tag, input bit need_consecutive);
    int bad;
    bad = 0;
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i] || got_hold[i] !== 1'b1 ||
          (need_consecutive && got_cyc[i] != got_cyc[0] + i)) begin
        if (bad == 0)
          $display("FAIL %s_write[%0d]: got addr/data 0x%0h hold %0b cyc %0d, expected 0x%0h hold 1 cyc %0d",
                   tag, i, got_q[i], got_hold[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  // ---------------- driver ----------------
  // Presents one byte and returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %0b for byte 0x%0h, expected 1", in_ready, b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    ahi;
    logic [7:0]    alo;
    logic [7:0]    len;
    logic [7:0]    seed;
    logic [7:0]    step;
    bit            garbage;
    bit            bad_csum;
    logic [7:0]    fixed_csum;
    logic [AW-1:0] exp_start;
    int            exp_n;
    bit            exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_frame(input vec_t v, input int idx);
    logic [7:0]    sum;
    logic [7:0]    b;
    logic [AW-1:0] a;
    bit            e_err;
    int            d0, e0;
    string         tag;
    tag   = $sformatf("v%0d", idx);
    e_err = CSUM_EN && v.exp_err;
    clear_sb();
    d0 = done_cnt;
    e0 = err_cnt;
    if (v.garbage) begin
      send_byte(8'h00);
      send_byte(8'hA4);
    end
    send_byte(8'hA5);
    check({tag, "_hold_after_sync"}, cpu_hold, 1);
    send_byte(v.ahi);
    send_byte(v.alo);
    send_byte(v.len);
    sum = v.ahi + v.alo + v.len;
    for (int i = 0; i < v.exp_n; i++) begin
      b   = v.seed + 8'(v.step * i);
      a   = v.exp_start + AW'(i);
      sum = sum + b;
      exp_q.push_back({a, b});
      send_byte(b);
    end
    if (CSUM_EN) send_byte(v.bad_csum ? v.fixed_csum : 8'h00 - sum);
    in_valid = 1'b0;
    // FIN cycle.
    check({tag, "_fin_ready"}, in_ready, 0);
    check({tag, "_fin_hold"}, cpu_hold, 1);
    @(negedge clk);
    check({tag, "_done"}, done, !e_err);
    check({tag, "_err"}, err, e_err);
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_hold_after"}, cpu_hold, 0);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, done_cnt - d0, e_err ? 0 : 1);
    check({tag, "_err_pulse_len"}, err_cnt - e0, e_err ? 1 : 0);
    compare_writes(tag, 1'b1);
  endtask

  // ---------------- main ----------------
  initial begin
    //         ahi    alo    len    seed   step   garb  bad   fcs    start     n    err
    vecs[0] = '{8'h12, 8'h34, 8'h03, 8'hAA, 8'h11, 1'b0, 1'b0, 8'h00, 15'h1234, 3,   1'b0};
    vecs[1] = '{8'h7F, 8'hFF, 8'h02, 8'h11, 8'h11, 1'b0, 1'b0, 8'h00, 15'h7FFF, 2,   1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h02, 8'h11, 8'h11, 1'b0, 1'b0, 8'h00, 15'h7FFF, 2,   1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 15'h0000, 256, 1'b0};
    vecs[4] = '{8'h80, 8'h05, 8'h01, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 15'h0005, 1,   1'b0};
    vecs[5] = '{8'h00, 8'h10, 8'h01, 8'h55, 8'h00, 1'b1, 1'b1, 8'hFF, 15'h0010, 1,   1'b1};

    // Reset held 5 cycles with a valid SYNC on the bus.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);
    @(negedge clk);
    check("rst_no_writes", got_q.size(), 0);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // Reset after 2 of 4 data bytes.
    clear_sb();
    begin
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h40);
      send_byte(8'h04);
      send_byte(8'h10);
      send_byte(8'h20);
      exp_q.push_back({15'h0040, 8'h10});
      exp_q.push_back({15'h0041, 8'h20});
      rst_n   = 1'b0;
      in_data = 8'h30;
      @(posedge clk);
      @(negedge clk);
      check("abort_hold", cpu_hold, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_ready", in_ready, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_no_err", err_cnt - e0, 0);
      compare_writes("abort", 1'b1);
    end

    // Fresh frame after the abort.
    run_frame(vecs[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
